// File: rtl/gps_pkg.sv
// Shared GPS baseband definitions: code length, chip sign mapping and the
// accumulator width rule used by the correlator and the NCO blocks.
package gps_pkg;

    localparam int CA_CODE_LEN = 1023;

    // Epoch sums of 1023 terms of magnitude up to 2^(SAMPLE_W-1) fit with
    // 11 extra bits of headroom, sign included.
    function automatic int acc_width(input int sample_w);
        return sample_w + 11;
    endfunction

    // GPS convention: chip 0 maps to +1, chip 1 maps to -1.
    function automatic logic signed [1:0] chip_to_sign(input logic chip);
        return chip ? 2'sb11 : 2'sb01;
    endfunction

endpackage

// File: rtl/corr_acc.sv
// Single sign-flip integrate-and-dump accumulator. The sample is wiped by the
// replica chip, summed every cycle, and captured into dump_value on dump.
module corr_acc
    import gps_pkg::*;
#(
    parameter int SAMPLE_W = 3,
    parameter int ACC_W    = acc_width(SAMPLE_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       chip,
    input  logic                       dump,
    output logic signed [ACC_W-1:0]    dump_value
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;

    // Widen before negating so the most negative sample flips exactly.
    always_comb begin
        sample_ext = ACC_W'(sample);
        term       = (chip_to_sign(chip) < 0) ? -sample_ext : sample_ext;
        sum        = acc + term;
    end

    // Integrate each cycle; on dump publish the completed sum and restart at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            dump_value <= '0;
        end else if (dump) begin
            dump_value <= sum;
            acc        <= '0;
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/ca_correlator.sv
// Early/prompt/late C/A-code correlator. Integrates I and Q against three
// replica phases over each 1023-chip epoch and presents the six sums to the
// tracking processor through a valid/ready handshake with sticky overrun.
module ca_correlator
    import gps_pkg::*;
#(
    parameter int SAMPLE_W = 3,
    parameter int ACC_W    = acc_width(SAMPLE_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       chip_in,
    input  logic signed [SAMPLE_W-1:0] i_in,
    input  logic signed [SAMPLE_W-1:0] q_in,
    output logic signed [ACC_W-1:0]    ie_out,
    output logic signed [ACC_W-1:0]    ip_out,
    output logic signed [ACC_W-1:0]    il_out,
    output logic signed [ACC_W-1:0]    qe_out,
    output logic signed [ACC_W-1:0]    qp_out,
    output logic signed [ACC_W-1:0]    ql_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       epoch_tick,
    output logic                       overrun
);

    logic [10:0] chip_cnt;
    logic        prompt_chip;
    logic        late_chip;
    logic        dump;

    // The last chip of the epoch is the dump cycle.
    always_comb begin
        dump = (chip_cnt == 11'(CA_CODE_LEN - 1));
    end

    // Epoch chip counter and the two-stage replica delay line (reset to chip 0 = +1).
    always_ff @(posedge clk) begin
        if (reset) begin
            chip_cnt    <= '0;
            prompt_chip <= 1'b0;
            late_chip   <= 1'b0;
        end else begin
            chip_cnt    <= dump ? 11'd0 : chip_cnt + 11'd1;
            prompt_chip <= chip_in;
            late_chip   <= prompt_chip;
        end
    end

    // A dump always leaves data pending; overwriting unconsumed data is sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            epoch_tick <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            epoch_tick <= dump;
            if (dump) begin
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_ie (
        .clk(clk), .reset(reset), .sample(i_in), .chip(chip_in),
        .dump(dump), .dump_value(ie_out)
    );

    corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_ip (
        .clk(clk), .reset(reset), .sample(i_in), .chip(prompt_chip),
        .dump(dump), .dump_value(ip_out)
    );

    corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_il (
        .clk(clk), .reset(reset), .sample(i_in), .chip(late_chip),
        .dump(dump), .dump_value(il_out)
    );

    corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_qe (
        .clk(clk), .reset(reset), .sample(q_in), .chip(chip_in),
        .dump(dump), .dump_value(qe_out)
    );

    corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_qp (
        .clk(clk), .reset(reset), .sample(q_in), .chip(prompt_chip),
        .dump(dump), .dump_value(qp_out)
    );

    corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_ql (
        .clk(clk), .reset(reset), .sample(q_in), .chip(late_chip),
        .dump(dump), .dump_value(ql_out)
    );

endmodule
